// File: rtl/bidir_bus_trans_arb.sv
// Registered bidirectional A<->B word mover with round-robin direction arbitration,
// burst limiting and bus-idle turnaround cycles between direction changes.
module bidir_bus_trans_arb #(
  parameter int WIDTH      = 6,
  parameter int MAXBURST   = 8,
  parameter int TURNAROUND = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] ain,
  input  logic             areq,
  input  logic [WIDTH-1:0] bin,
  input  logic             breq,
  input  logic             flowvalve,
  input  logic             noconflict,
  input  logic             prioritystatus,
  output logic [WIDTH-1:0] bout,
  output logic             bvalid,
  output logic [WIDTH-1:0] aout,
  output logic             avalid,
  output logic [1:0]       dirstatus,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_ATOB = 2'b01;
  localparam logic [1:0] S_BTOA = 2'b10;
  localparam logic [1:0] S_TURN = 2'b11;

  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  localparam int CW = (MAXBURST < 2) ? 1 : $clog2(MAXBURST + 1);
  localparam int TW = (TURNAROUND < 2) ? 1 : $clog2(TURNAROUND + 1);

  localparam logic [CW-1:0] MAXC  = CW'(MAXBURST);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [TW-1:0] TLOAD = (TURNAROUND > 0) ? TW'(TURNAROUND - 1) : '0;

  logic [1:0]    state, state_n;
  logic [CW-1:0] count, count_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          lastdir, lastdir_n;
  logic          pend_b, pend_b_n;
  logic          load_a, load_b;
  logic          ok;

  always_comb begin
    ok        = flowvalve & (noconflict | prioritystatus);
    state_n   = state;
    count_n   = count;
    tcnt_n    = tcnt;
    lastdir_n = lastdir;
    pend_b_n  = pend_b;
    load_a    = 1'b0;
    load_b    = 1'b0;

    unique case (state)
      S_IDLE: begin
        // A grant from IDLE moves the first word on the same edge.
        if (ok && (areq || breq)) begin
          count_n = ONE;
          if (areq && (!breq || lastdir == LAST_B)) begin
            state_n = S_ATOB;
            load_b  = 1'b1;
          end else begin
            state_n = S_BTOA;
            load_a  = 1'b1;
          end
        end
      end

      S_ATOB: begin
        if (ok) begin
          if (breq && (!areq || count == MAXC)) begin
            lastdir_n = LAST_A;
            if (TURNAROUND == 0) begin
              state_n = S_BTOA;
              load_a  = 1'b1;
              count_n = ONE;
            end else begin
              state_n  = S_TURN;
              tcnt_n   = TLOAD;
              pend_b_n = 1'b1;
              count_n  = '0;
            end
          end else if (!areq) begin
            state_n   = S_IDLE;
            lastdir_n = LAST_A;
            count_n   = '0;
          end else begin
            load_b  = 1'b1;
            count_n = (count == MAXC) ? ONE : count + 1'b1;
          end
        end
      end

      S_BTOA: begin
        if (ok) begin
          if (areq && (!breq || count == MAXC)) begin
            lastdir_n = LAST_B;
            if (TURNAROUND == 0) begin
              state_n = S_ATOB;
              load_b  = 1'b1;
              count_n = ONE;
            end else begin
              state_n  = S_TURN;
              tcnt_n   = TLOAD;
              pend_b_n = 1'b0;
              count_n  = '0;
            end
          end else if (!breq) begin
            state_n   = S_IDLE;
            lastdir_n = LAST_B;
            count_n   = '0;
          end else begin
            load_a  = 1'b1;
            count_n = (count == MAXC) ? ONE : count + 1'b1;
          end
        end
      end

      S_TURN: begin
        // Turnaround always runs to completion; ok only gates the first word after it.
        if (tcnt != '0) begin
          tcnt_n = tcnt - 1'b1;
        end else if (pend_b ? breq : areq) begin
          state_n = pend_b ? S_BTOA : S_ATOB;
          if (ok) begin
            count_n = ONE;
            load_a  = pend_b;
            load_b  = !pend_b;
          end else begin
            count_n = '0;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      count   <= '0;
      tcnt    <= '0;
      lastdir <= LAST_B;
      pend_b  <= 1'b0;
      bout    <= '0;
      aout    <= '0;
      bvalid  <= 1'b0;
      avalid  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      tcnt    <= tcnt_n;
      lastdir <= lastdir_n;
      pend_b  <= pend_b_n;
      bvalid  <= load_b;
      avalid  <= load_a;
      busy    <= (state_n != S_IDLE);
      if (load_b) bout <= ain;
      if (load_a) aout <= bin;
    end
  end

  assign dirstatus = state;

endmodule

// File: tb/tb_bidir_bus_trans_arb.sv
// Directed and randomized checks of bidir_bus_trans_arb against a side-symmetric
// reference model of grants, bursts and turnarounds.
module tb_bidir_bus_trans_arb;

  localparam int W  = 6;
  localparam int MB = 8;
  localparam int TA = 1;

  localparam int M_IDLE = 0;
  localparam int M_OWN  = 1;
  localparam int M_TURN = 2;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] ain, bin;
  logic         areq, breq, flowvalve, noconflict, prioritystatus;
  logic [W-1:0] bout, aout;
  logic         bvalid, avalid, busy;
  logic [1:0]   dirstatus;

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model; index 0 is side A, index 1 is side B.
  int           m_mode = M_IDLE;
  int           m_side = 0;
  int           m_last = 1;
  int           m_words = 0;
  int           m_turn_left = 0;
  logic [W-1:0] m_fwd[2];
  logic         m_valid[2];

  bidir_bus_trans_arb #(
    .WIDTH(W),
    .MAXBURST(MB),
    .TURNAROUND(TA)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ain(ain),
    .areq(areq),
    .bin(bin),
    .breq(breq),
    .flowvalve(flowvalve),
    .noconflict(noconflict),
    .prioritystatus(prioritystatus),
    .bout(bout),
    .bvalid(bvalid),
    .aout(aout),
    .avalid(avalid),
    .dirstatus(dirstatus),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic grant(input int s, input bit ok, input bit rq, input logic [W-1:0] d);
    m_mode = M_OWN;
    m_side = s;
    if (ok && rq) begin
      m_fwd[s]   = d;
      m_valid[s] = 1'b1;
      m_words    = 1;
    end else begin
      m_words = 0;
    end
  endtask

  task automatic model_step();
    bit           req[2];
    logic [W-1:0] din[2];
    bit           ok;
    int           s, o;
    req[0] = areq;  req[1] = breq;
    din[0] = ain;   din[1] = bin;
    ok = flowvalve && (noconflict || prioritystatus);
    m_valid[0] = 1'b0;
    m_valid[1] = 1'b0;
    if (reset) begin
      m_mode = M_IDLE; m_words = 0; m_last = 1;
      m_fwd[0] = '0; m_fwd[1] = '0;
    end else if (m_mode == M_IDLE) begin
      if (ok && (req[0] || req[1])) begin
        s = (req[0] && req[1]) ? 1 - m_last : (req[0] ? 0 : 1);
        grant(s, ok, req[s], din[s]);
      end
    end else if (m_mode == M_TURN) begin
      m_turn_left--;
      if (m_turn_left == 0) begin
        if (req[m_side]) grant(m_side, ok, 1'b1, din[m_side]);
        else m_mode = M_IDLE;
      end
    end else begin
      s = m_side;
      o = 1 - s;
      if (ok) begin
        if (req[o] && (!req[s] || m_words == MB)) begin
          m_last = s;
          if (TA == 0) grant(o, ok, 1'b1, din[o]);
          else begin
            m_mode = M_TURN; m_turn_left = TA; m_side = o; m_words = 0;
          end
        end else if (!req[s]) begin
          m_mode = M_IDLE; m_last = s; m_words = 0;
        end else begin
          m_fwd[s]   = din[s];
          m_valid[s] = 1'b1;
          m_words    = (m_words == MB) ? 1 : m_words + 1;
        end
      end
    end
  endtask

  function automatic logic [1:0] m_dir();
    if (m_mode == M_IDLE) return 2'b00;
    if (m_mode == M_TURN) return 2'b11;
    return (m_side == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic compare_all();
    check("bvalid", bvalid, m_valid[0]);
    check("avalid", avalid, m_valid[1]);
    check("bout", bout, m_fwd[0]);
    check("aout", aout, m_fwd[1]);
    check("dirstatus", dirstatus, m_dir());
    check("busy", busy, m_mode != M_IDLE);
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1; areq = 1'b0; breq = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0] held;
    reset = 1'b1; ain = '0; bin = '0; areq = 1'b0; breq = 1'b0;
    flowvalve = 1'b1; noconflict = 1'b1; prioritystatus = 1'b0;
    m_fwd[0] = '0; m_fwd[1] = '0; m_valid[0] = 1'b0; m_valid[1] = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_bout", bout, 0);
    check("rst_aout", aout, 0);
    check("rst_dir", dirstatus, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;

    // A->B stream, one-cycle latency
    areq = 1'b1; ain = 6'h2A;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ab_bout", bout, 32'h2A);
      check("ab_bvalid", bvalid, 1);
      check("ab_dir", dirstatus, 2'b01);
      check("ab_avalid", avalid, 0);
    end
    areq = 1'b0; tick();
    check("ab_idle", dirstatus, 2'b00);

    // Tie from reset goes to A, then turnaround to B
    do_reset();
    areq = 1'b1; breq = 1'b1; ain = 6'h11; bin = 6'h22;
    tick(); check("tie_dir", dirstatus, 2'b01);
    tick();
    areq = 1'b0; tick();
    check("turn_dir", dirstatus, 2'b11);
    check("turn_av", avalid, 0);
    check("turn_bv", bvalid, 0);
    bin = 6'h35; tick();
    check("ba_dir", dirstatus, 2'b10);
    check("ba_avalid", avalid, 1);
    check("ba_aout", aout, 32'h35);
    breq = 1'b0; tick();

    // Burst limit alternation with both sides requesting
    do_reset();
    areq = 1'b1; breq = 1'b1;
    for (int i = 0; i < 36; i++) begin
      ain = W'($urandom); bin = W'($urandom);
      tick();
      if (i < 18) begin
        check("mb_bv", bvalid, (i < 8) ? 1 : 0);
        check("mb_av", avalid, (i >= 9 && i < 17) ? 1 : 0);
      end
    end

    // Conflict blocks, priority override releases
    do_reset();
    noconflict = 1'b0; prioritystatus = 1'b0; areq = 1'b1; ain = 6'h0F;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("cf_dir", dirstatus, 2'b00);
      check("cf_bv", bvalid, 0);
    end
    prioritystatus = 1'b1; tick();
    check("pr_bv", bvalid, 1);
    check("pr_bout", bout, 32'h0F);
    noconflict = 1'b1; prioritystatus = 1'b0; areq = 1'b0; tick();

    // flowvalve stall mid-burst keeps the burst count
    do_reset();
    areq = 1'b1; breq = 1'b1;
    for (int i = 0; i < 3; i++) begin ain = W'($urandom); tick(); end
    flowvalve = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ain = W'($urandom); tick();
      check("fv_bv", bvalid, 0);
      check("fv_dir", dirstatus, 2'b01);
    end
    flowvalve = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ain = W'($urandom); tick();
      check("fv_resume_bv", bvalid, (i < 5) ? 1 : 0);
    end
    check("fv_turn", dirstatus, 2'b11);
    areq = 1'b0; breq = 1'b0; tick(); tick();

    // Reset during B->A: no effect until the edge
    do_reset();
    breq = 1'b1;
    for (int i = 0; i < 3; i++) begin bin = W'($urandom); tick(); end
    held = aout;
    reset = 1'b1; bin = W'($urandom);
    #2;
    compare_all();
    check("rstw_aout", aout, held);
    check("rstw_av", avalid, 1);
    tick();
    check("rst_mid_aout", aout, 0);
    check("rst_mid_av", avalid, 0);
    check("rst_mid_dir", dirstatus, 0);
    reset = 1'b0; breq = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 79) == 0);
      areq = ($urandom_range(0, 3) != 0);
      breq = ($urandom_range(0, 3) != 0);
      flowvalve = ($urandom_range(0, 7) != 0);
      noconflict = ($urandom_range(0, 3) != 0);
      prioritystatus = ($urandom_range(0, 1) != 0);
      ain = W'($urandom); bin = W'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
